// File: rtl/pq_cmd_issuer.sv
// Priority-queue command issuer: buffers ENQ/DEQ/REP commands and
// turns each one into a single enq/deq pulse for the PQ.
module pq_cmd_issuer #(
  parameter int KW    = 16,
  parameter int DEPTH = 4,
  parameter int ERRW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  input  logic [1:0]      cmd_op,
  input  logic [KW-1:0]   cmd_kv,
  output logic            cmd_ready,
  output logic            pq_enq,
  output logic            pq_deq,
  output logic [KW-1:0]   pq_kvi,
  input  logic            pq_busy,
  input  logic            pq_full,
  input  logic            pq_empty,
  input  logic [KW-1:0]   pq_kvo,
  output logic            res_valid,
  output logic [KW-1:0]   res_kv,
  output logic [ERRW-1:0] err_full,
  output logic [ERRW-1:0] err_empty,
  output logic            idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] OP_ENQ = 2'b01;
  localparam logic [1:0] OP_DEQ = 2'b10;
  localparam logic [1:0] OP_REP = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  logic [KW+1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  state_t         state;
  state_t         state_nx;
  logic [1:0]     op_q;
  logic [KW-1:0]  kv_q;

  logic           push;
  logic           pop;
  logic           do_enq;
  logic           do_deq;
  logic           inc_full;
  logic           inc_empty;

  assign cmd_ready = (count != CW'(DEPTH));
  assign push      = cmd_valid & cmd_ready & (cmd_op != 2'b00);
  assign pop       = (state == IDLE) & (count != '0) & ~pq_busy;

  assign pq_enq = do_enq;
  assign pq_deq = do_deq;
  assign pq_kvi = kv_q;
  assign idle   = (count == '0) && (state == IDLE);

  // Storage needs no reset: the count alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_kv};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    do_enq    = 1'b0;
    do_deq    = 1'b0;
    inc_full  = 1'b0;
    inc_empty = 1'b0;
    unique case (state)
      IDLE: begin
        if (pop) state_nx = ISSUE;
      end
      ISSUE: begin
        state_nx = WAIT;
        unique case (op_q)
          OP_ENQ: begin
            if (pq_full) inc_full = 1'b1;
            else         do_enq   = 1'b1;
          end
          OP_DEQ: begin
            if (pq_empty) inc_empty = 1'b1;
            else          do_deq    = 1'b1;
          end
          OP_REP: begin
            // Replace leaves occupancy unchanged, so full only
            // matters once it degrades to a plain enqueue.
            if (!pq_empty) begin
              do_enq = 1'b1;
              do_deq = 1'b1;
            end else if (pq_full) begin
              inc_full = 1'b1;
            end else begin
              do_enq = 1'b1;
            end
          end
          default: ;
        endcase
      end
      WAIT: begin
        if (!pq_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      kv_q      <= '0;
      res_valid <= 1'b0;
      res_kv    <= '0;
      err_full  <= '0;
      err_empty <= '0;
    end else begin
      state     <= state_nx;
      res_valid <= do_deq;
      if (pop) begin
        {op_q, kv_q} <= mem[rd_ptr];
      end
      if (do_deq) res_kv <= pq_kvo;
      if (inc_full && (err_full != '1)) begin
        err_full <= err_full + ERRW'(1);
      end
      if (inc_empty && (err_empty != '1)) begin
        err_empty <= err_empty + ERRW'(1);
      end
    end
  end

endmodule
